// File: rtl/sum_column_linebuf.sv
// ============================================================================
// sum_column_linebuf : vertical stage of the KSZ x KSZ box sum over row sums
// Revision: 1.0
// ============================================================================
`default_nettype none

module sum_column_linebuf #(
   parameter int KSZ = 3,
   parameter int DW  = 8,
   parameter int IW  = 640,
   parameter int AW  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din_vsync,
   input  logic              din_hsync,
   input  logic [2*DW-1:0]   din,
   output logic              dout_top_vsync,
   output logic              dout_top_hsync,
   output logic [2*DW-1:0]   dout_top,
   output logic              dout_full_vsync,
   output logic              dout_full_hsync,
   output logic [2*DW-1:0]   dout_full
);

   localparam int SW = 2 * DW;
   localparam int CW = $clog2(IW + 1);
   localparam int XW = (CW > AW) ? CW : AW;
   localparam int RW = $clog2(KSZ);
   localparam logic [XW-1:0] C_IW   = XW'(IW);
   localparam logic [RW-1:0] C_RMAX = RW'(KSZ - 1);

   logic          vsync_q, hsync_q, full_ok_q, full_ok_d;
   logic [SW-1:0] top_q, full_q, sum_d;
   logic [XW-1:0] x_cnt_q, x_cnt_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d, row_eff;
   logic [AW-1:0] addr;
   logic          vs_rise, hs_fall, in_range;
   logic [SW-1:0] rd [1:KSZ-1];

   assign vs_rise  = din_vsync & ~vsync_q;
   assign hs_fall  = hsync_q & ~din_hsync;
   assign in_range = (x_cnt_q < C_IW);
   assign addr     = x_cnt_q[AW-1:0];
   // A line starting on the vsync edge already belongs to row 0 of the new frame
   assign row_eff  = vs_rise ? '0 : row_cnt_q;

   for (genvar k = 1; k < KSZ; k++) begin : g_stage
      logic [SW-1:0] mem [0:IW-1];
      logic [SW-1:0] wr_data;

      assign rd[k] = mem[addr];

      if (k == 1) begin : g_first
         assign wr_data = din;
      end else begin : g_chain
         assign wr_data = rd[k-1];
      end

      always_ff @(posedge clk) begin
         if (din_hsync && in_range) begin
            mem[addr] <= wr_data;
         end
      end
   end

   always_comb begin
      x_cnt_d = x_cnt_q;
      if (!din_hsync) begin
         x_cnt_d = '0;
      end else if (in_range) begin
         x_cnt_d = x_cnt_q + XW'(1);
      end

      row_cnt_d = row_cnt_q;
      if (vs_rise) begin
         row_cnt_d = '0;
      end else if (hs_fall && din_vsync && (row_cnt_q != C_RMAX)) begin
         row_cnt_d = row_cnt_q + RW'(1);
      end

      sum_d = din;
      for (int k = 1; k < KSZ; k++) begin
         if (in_range && (row_eff >= RW'(k))) begin
            sum_d = sum_d + rd[k];
         end
      end

      full_ok_d = full_ok_q;
      if (din_hsync) begin
         full_ok_d = (row_eff == C_RMAX);
      end else if (vs_rise) begin
         full_ok_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_q   <= 1'b0;
         hsync_q   <= 1'b0;
         x_cnt_q   <= '0;
         row_cnt_q <= '0;
         full_ok_q <= 1'b0;
         top_q     <= '0;
         full_q    <= '0;
      end else begin
         vsync_q   <= din_vsync;
         hsync_q   <= din_hsync;
         x_cnt_q   <= x_cnt_d;
         row_cnt_q <= row_cnt_d;
         full_ok_q <= full_ok_d;
         top_q     <= din_hsync ? sum_d : '0;
         full_q    <= (din_hsync && full_ok_d) ? sum_d : '0;
      end
   end

   assign dout_top_vsync  = vsync_q;
   assign dout_top_hsync  = hsync_q;
   assign dout_top        = top_q;
   assign dout_full_vsync = vsync_q & full_ok_q;
   assign dout_full_hsync = hsync_q & full_ok_q;
   assign dout_full       = full_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_column_linebuf.sv
// ============================================================================
// tb_sum_column_linebuf : directed scoreboard bench for sum_column_linebuf
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sum_column_linebuf;

   localparam int KSZ = 3;
   localparam int DW  = 8;
   localparam int IW  = 4;
   localparam int AW  = 2;

   typedef struct packed {
      logic        tv;
      logic        th;
      logic [15:0] top;
      logic        fv;
      logic        fh;
      logic [15:0] full;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        din_vsync, din_hsync;
   logic [15:0] din;
   logic        dout_top_vsync, dout_top_hsync, dout_full_vsync, dout_full_hsync;
   logic [15:0] dout_top, dout_full;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   sum_column_linebuf #(.KSZ(KSZ), .DW(DW), .IW(IW), .AW(AW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .din_vsync       (din_vsync),
      .din_hsync       (din_hsync),
      .din             (din),
      .dout_top_vsync  (dout_top_vsync),
      .dout_top_hsync  (dout_top_hsync),
      .dout_top        (dout_top),
      .dout_full_vsync (dout_full_vsync),
      .dout_full_hsync (dout_full_hsync),
      .dout_full       (dout_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
         e = sb.pop_front();
         chk("top_vsync",  16'(dout_top_vsync),  16'(e.tv));
         chk("top_hsync",  16'(dout_top_hsync),  16'(e.th));
         chk("top",        dout_top,             e.top);
         chk("full_vsync", 16'(dout_full_vsync), 16'(e.fv));
         chk("full_hsync", 16'(dout_full_hsync), 16'(e.fh));
         chk("full",       dout_full,            e.full);
      end
   endtask

   // One input cycle; the expected output for it is checked after the next edge.
   task automatic tick(input logic v, input logic h, input logic [15:0] d,
                       input logic [15:0] e, input logic ef, input logic rst_cyc);
      exp_t x;
      din_vsync = v;
      din_hsync = h;
      din       = d;
      rst_n     = ~rst_cyc;
      if (rst_cyc) begin
         x = '0;
      end else begin
         x.tv   = v;
         x.th   = h;
         x.top  = h ? e : 16'h0;
         x.fv   = v & ef;
         x.fh   = h & ef;
         x.full = (h & ef) ? e : 16'h0;
      end
      sb.push_back(x);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic blank(input int n, input logic v, input logic ef);
      for (int i = 0; i < n; i++) tick(v, 1'b0, 16'h0, 16'h0, ef, 1'b0);
   endtask

   // Columns >= IW use the _hi data / expectation.
   task automatic line(input int n, input logic [15:0] dlo, input logic [15:0] dhi,
                       input logic [15:0] elo, input logic [15:0] ehi, input logic ef);
      for (int c = 0; c < n; c++) begin
         if (c < IW) tick(1'b1, 1'b1, dlo, elo, ef, 1'b0);
         else        tick(1'b1, 1'b1, dhi, ehi, ef, 1'b0);
      end
      blank(2, 1'b1, ef);
   endtask

   task automatic frame_start();
      blank(2, 1'b0, 1'b0);
      blank(2, 1'b1, 1'b0);
   endtask

   task automatic frame_const3();
      frame_start();
      line(4, 16'd3, 16'd3, 16'd3, 16'd3, 1'b0);
      line(4, 16'd3, 16'd3, 16'd6, 16'd6, 1'b0);
      line(4, 16'd3, 16'd3, 16'd9, 16'd9, 1'b1);
      line(4, 16'd3, 16'd3, 16'd9, 16'd9, 1'b1);
      blank(2, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      din_vsync = 1'b0;
      din_hsync = 1'b0;
      din = 16'h0;

      // Reset state
      tick(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

      // Constant din=3
      frame_const3();

      // Line values 1,2,4,8 over stale buffers
      frame_start();
      line(4, 16'd1, 16'd1, 16'd1,  16'd1,  1'b0);
      line(4, 16'd2, 16'd2, 16'd3,  16'd3,  1'b0);
      line(4, 16'd4, 16'd4, 16'd7,  16'd7,  1'b1);
      line(4, 16'd8, 16'd8, 16'd14, 16'd14, 1'b1);
      blank(2, 1'b0, 1'b0);

      // Next frame starts with din=5: stale rows must be masked
      frame_start();
      line(4, 16'd5, 16'd5, 16'd5,  16'd5,  1'b0);
      line(4, 16'd5, 16'd5, 16'd10, 16'd10, 1'b0);
      line(4, 16'd5, 16'd5, 16'd15, 16'd15, 1'b1);
      blank(2, 1'b0, 1'b0);

      // Modulo wrap
      frame_start();
      line(4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
      line(4, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE, 1'b0);
      line(4, 16'hFFFF, 16'hFFFF, 16'hFFFD, 16'hFFFD, 1'b1);
      blank(2, 1'b0, 1'b0);

      // Overlong line: pixels beyond IW pass din only and write nothing
      frame_start();
      line(4, 16'd1, 16'd1,  16'd1, 16'd1,  1'b0);
      line(6, 16'd2, 16'd50, 16'd3, 16'd50, 1'b0);
      line(4, 16'd4, 16'd4,  16'd7, 16'd7,  1'b1);
      blank(2, 1'b0, 1'b0);

      // Reset in the middle of line 1
      frame_start();
      line(4, 16'd3, 16'd3, 16'd3, 16'd3, 1'b0);
      tick(1'b1, 1'b1, 16'd3, 16'd6, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 16'd3, 16'd6, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 16'd3, 16'd0, 1'b0, 1'b1);
      blank(2, 1'b0, 1'b0);
      frame_const3();

      chk("sb_empty", 16'(sb.size()), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
